led_pattern_ctrl: RTL and testbench

Parametrised LED pattern engine for the board-level LED bank. It generates one-hot shift, ping-pong and bar-fill patterns on a WIDTH-bit LED bus, with a built-in step-rate divider and run/pause control. Optional PWM dimming is available. It sits between the board clock/reset and the LED pins, and is driven by switch inputs for mode and enable.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_pattern_ctrl.sv | 138 +++++++++++++
 tb/tb_led_pattern_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED pattern engine.
//   mode_e    : pattern select encodings (shift right / shift left / bounce / bar)
//   DIR_RIGHT : bounce direction towards bit 0
//   DIR_LEFT  : bounce direction towards bit WIDTH-1
// -----------------------------------------------------------------------------
package led_pkg;

  typedef enum logic [1:0] {
    MODE_SHR    = 2'b00,
    MODE_SHL    = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_BAR    = 2'b11
  } mode_e;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// -----------------------------------------------------------------------------
// led_tick_gen
// Step-rate divider. Counts enabled clk cycles and flags the edge on which a
// pattern step should happen (every DIV enabled cycles).
//   clk   in  system clock
//   rst_n in  asynchronous active-low reset
//   en    in  count enable; counter holds while low
//   clr   in  synchronous clear; suppresses tick on the same edge
//   tick  out high during the cycle whose closing edge is a step edge
// -----------------------------------------------------------------------------
module led_tick_gen #(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Combinational so the step lands on the same edge that wraps the counter.
  assign tick = en && !clr && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// led_pattern_ctrl
// LED pattern engine: one-hot shift right/left, ping-pong bounce and bar fill
// on a WIDTH-bit LED bus, stepped by led_tick_gen every DIV enabled cycles.
// Optional PWM dimming is compiled in when the macro LED_PWM_EN is defined.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   en     in  run (1) / pause (0)
//   mode   in  pattern select (see led_pkg::mode_e)
//   bright in  brightness level (LED_PWM_EN builds only)
//   led    out LED drive, active-high
//   step   out one-cycle pulse in the first cycle a new pattern is visible
//
// Valid/ready note: there is no handshake here; mode and en are level inputs
// sampled on every clk edge, and step is a registered single-cycle strobe.
// -----------------------------------------------------------------------------
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV      = 50_000_000,
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [1:0]          mode,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] bright,
`endif
  output logic [WIDTH-1:0]    led,
  output logic                step
);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < 2)    begin : g_bad_width $error("WIDTH must be at least 2");   end
  if (DIV < 1)      begin : g_bad_div   $error("DIV must be at least 1");     end
  if (PWM_BITS < 1) begin : g_bad_pwm   $error("PWM_BITS must be at least 1"); end

  localparam logic [WIDTH-1:0] PAT_MSB  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] PAT_LSB  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] PAT_ONES = '1;

  logic [WIDTH-1:0] pat;
  logic             dir;
  mode_e            mode_q;
  logic             mode_chg;
  logic             tick;

  function automatic logic [WIDTH-1:0] seed_pat(input mode_e m);
    case (m)
      MODE_SHL: seed_pat = PAT_LSB;
      MODE_BAR: seed_pat = '0;
      default:  seed_pat = PAT_MSB;
    endcase
  endfunction

  // A mode change restarts the divider so the first step of the new pattern
  // comes a full DIV cycles after the seed appears.
  assign mode_chg = (mode != mode_q);

  led_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (mode_chg),
    .tick  (tick)
  );

  // Pattern FSM: mode_q/dir/pat form the state, step is a registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat    <= PAT_MSB;
      dir    <= DIR_RIGHT;
      mode_q <= MODE_SHR;
      step   <= 1'b0;
    end else begin
      step <= 1'b0;
      if (mode_chg) begin
        mode_q <= mode_e'(mode);
        pat    <= seed_pat(mode_e'(mode));
        dir    <= DIR_RIGHT;
      end else if (tick) begin
        step <= 1'b1;
        case (mode_q)
          MODE_SHR: begin
            if (pat == '0 || pat == PAT_LSB) pat <= PAT_MSB;
            else                              pat <= pat >> 1;
          end
          MODE_SHL: begin
            if (pat == '0 || pat == PAT_MSB) pat <= PAT_LSB;
            else                              pat <= pat << 1;
          end
          MODE_BOUNCE: begin
            if (pat == '0) begin
              pat <= PAT_MSB;
              dir <= DIR_RIGHT;
            end else if (dir == DIR_RIGHT) begin
              pat <= pat >> 1;
              // Turn on the edge that lands on bit 0 so it is not shown twice.
              if (pat[1]) dir <= DIR_LEFT;
            end else begin
              pat <= pat << 1;
              if (pat[WIDTH-2]) dir <= DIR_RIGHT;
            end
          end
          MODE_BAR: begin
            if (pat == PAT_ONES) pat <= '0;
            else                 pat <= {1'b1, pat[WIDTH-1:1]};
          end
        endcase
      end
    end
  end

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                pwm_on;

  // Full-scale bright forces the output permanently on instead of 15/16 duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      pwm_on  <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      pwm_on  <= (pwm_cnt < bright) || (bright == '1);
    end
  end

  assign led = pat & {WIDTH{pwm_on}};
`else
  assign led = pat;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_pattern_ctrl
// Directed bench for led_pattern_ctrl. Two instances share clk/rst_n:
//   dut3 : WIDTH=4, DIV=3 (shift, mode switch, pause, async reset)
//   dut1 : WIDTH=4, DIV=1 (bounce and bar fill sequences)
// PWM duty checks are compiled in with LED_PWM_EN.
// -----------------------------------------------------------------------------
module tb_led_pattern_ctrl;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       en3 = 1'b0, en1 = 1'b0;
  logic [1:0] mode3 = 2'b00, mode1 = 2'b00;
  logic [3:0] led3, led1;
  logic       step3, step1;
`ifdef LED_PWM_EN
  logic [3:0] bright3 = 4'hF, bright1 = 4'hF;
  localparam logic [3:0] RST_LED = 4'b0000;
`else
  localparam logic [3:0] RST_LED = 4'b1000;
`endif

  int total = 0;
  int bad   = 0;

  led_pattern_ctrl #(.WIDTH(4), .DIV(3), .PWM_BITS(4)) dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en3),
    .mode  (mode3),
`ifdef LED_PWM_EN
    .bright(bright3),
`endif
    .led   (led3),
    .step  (step3)
  );

  led_pattern_ctrl #(.WIDTH(4), .DIV(1), .PWM_BITS(4)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en1),
    .mode  (mode1),
`ifdef LED_PWM_EN
    .bright(bright1),
`endif
    .led   (led1),
    .step  (step1)
  );

  // ---------------- driver / check tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- expected sequences ----------------
  logic [3:0] shr_tbl [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [3:0] bnc_tbl [7] = '{4'b0100, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100};
  logic [3:0] bar_tbl [6] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0000, 4'b1000};

  initial begin
    // Reset state
    #12;
    check("rst_led3",  led3,  RST_LED);
    check("rst_step3", step3, 1'b0);
    check("rst_step1", step1, 1'b0);

    // Shift right, DIV=3: step every third edge
    en3   = 1'b1;
    mode3 = 2'b00;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      check($sformatf("shr_led_%0d", k),  led3,  shr_tbl[k/3]);
      check($sformatf("shr_step_%0d", k), step3, (k % 3 == 0));
    end

    // Mode switch at cnt=DIV-1: seed shown, no step, next step DIV later
    cyc();
    cyc();
    mode3 = 2'b01;
    cyc();
    check("sw_led_0",  led3,  4'b0001);
    check("sw_step_0", step3, 1'b0);
    cyc();
    cyc();
    check("sw_led_2",  led3,  4'b0001);
    check("sw_step_2", step3, 1'b0);
    cyc();
    check("sw_led_3",  led3,  4'b0010);
    check("sw_step_3", step3, 1'b1);

    // Pause at cnt=1 for 10 cycles
    cyc();
    check("pre_pause_step", step3, 1'b0);
    en3 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      check($sformatf("pause_led_%0d", k),  led3,  4'b0010);
      check($sformatf("pause_step_%0d", k), step3, 1'b0);
    end
    en3 = 1'b1;
    cyc();
    check("resume_led_1",  led3,  4'b0010);
    check("resume_step_1", step3, 1'b0);
    cyc();
    check("resume_led_2",  led3,  4'b0100);
    check("resume_step_2", step3, 1'b1);

    // Asynchronous reset mid-cycle, released with mode=01 still selected
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_led",  led3,  RST_LED);
    check("async_rst_step", step3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    check("rel_seed_led",  led3,  4'b0001);
    check("rel_seed_step", step3, 1'b0);
    cyc();
    cyc();
    check("rel_led_2", led3, 4'b0001);
    cyc();
    check("rel_led_3",  led3,  4'b0010);
    check("rel_step_3", step3, 1'b1);

    // Bounce, DIV=1
    mode1 = 2'b10;
    en1   = 1'b1;
    cyc();
    check("bnc_seed_led",  led1,  4'b1000);
    check("bnc_seed_step", step1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      cyc();
      check($sformatf("bnc_led_%0d", k),  led1,  bnc_tbl[k]);
      check($sformatf("bnc_step_%0d", k), step1, 1'b1);
    end

    // Bar fill, DIV=1
    mode1 = 2'b11;
    cyc();
    check("bar_seed_led",  led1,  4'b0000);
    check("bar_seed_step", step1, 1'b0);
    for (int k = 0; k < 6; k++) begin
      cyc();
      check($sformatf("bar_led_%0d", k),  led1,  bar_tbl[k]);
      check($sformatf("bar_step_%0d", k), step1, 1'b1);
    end

`ifdef LED_PWM_EN
    // Pattern held at 1000; measure duty over one 16-cycle PWM period
    begin
      int on_cnt;
      en1     = 1'b0;
      bright1 = 4'd4;
      cyc();
      cyc();
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        cyc();
        if (led1 == 4'b1000) on_cnt++;
      end
      check("pwm_duty_4", on_cnt, 4);

      bright1 = 4'd0;
      cyc();
      cyc();
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        cyc();
        if (led1 != 4'b0000) on_cnt++;
      end
      check("pwm_dark", on_cnt, 0);

      bright1 = 4'hF;
      cyc();
      cyc();
      on_cnt = 0;
      for (int k = 0; k < 16; k++) begin
        cyc();
        if (led1 == 4'b1000) on_cnt++;
      end
      check("pwm_full", on_cnt, 16);
    end
`endif

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
